qea_run_sequencer: RTL and testbench
====================================

Name: qea_run_sequencer

Overview:
- Upstream control stage for the QEA core; replaces bench-driven loading with synthesizable sequencing.
- Accepts a valid/ready stream of 64-bit gate-context words and writes them into the QEA context RAM.
- Writes the |0…0> initial state into state RAM, pulses start, waits for complete, and reports the execution cycle count.
- Sits between the host/DMA interface and QEA; all outputs drive QEA ports one-to-one.

Parameters:
- PE_NUM_WIDTH, 2, log2 of PE count
- PE_NUM, 4, number of PEs (state lanes per RAM word)
- DATA_WIDTH, 32, real/imag component width
- STATE_DATA_WIDTH, 64, one complex amplitude
- STATE_ADDR_WIDTH, 16, state RAM address width
- GATE_CONTEXT_DATA_WIDTH, 64, context word width
- GATE_CONTEXT_ADDR_WIDTH, 16, context RAM address width
- MAX_QBIT_WIDTH, 6, qubit-count field width
- NUM_FRAC_BIT, 30, fixed-point fraction bits (1.0 = 1<<NUM_FRAC_BIT)
- TIMEOUT_CYCLES, 1000000, maximum cycles in WAIT_COMPLETE before error

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- i_run  in  1  one-cycle request; sampled only in IDLE
- i_qbit_num  in  MAX_QBIT_WIDTH  qubit count, latched on accepted i_run
- s_ctx_valid  in  1  context beat valid
- s_ctx_ready  out  1  context beat ready
- s_ctx_data  in  GATE_CONTEXT_DATA_WIDTH  context word
- s_ctx_last  in  1  final context beat
- o_ctx_en  out  1  QEA i_ctx_en
- o_ctx_wea  out  1  QEA i_ctx_wea
- o_ctx_addr  out  GATE_CONTEXT_ADDR_WIDTH  QEA i_ctx_addr
- o_ctx_data  out  GATE_CONTEXT_DATA_WIDTH  QEA i_ctx_data
- o_state_ena  out  1  QEA i_state_ena
- o_state_wea  out  1  QEA i_state_wea
- o_state_addra  out  STATE_ADDR_WIDTH  QEA i_state_addra
- o_state_dina  out  PE_NUM*STATE_DATA_WIDTH  QEA i_state_dina
- o_start  out  1  QEA i_start pulse
- i_complete  in  1  QEA o_complete
- o_busy  out  1  high in any state other than IDLE
- o_done  out  1  one-cycle pulse on successful completion
- o_err  out  1  sticky error flag; cleared by the next accepted i_run or by rst
- o_ctx_count  out  GATE_CONTEXT_ADDR_WIDTH+1  number of context words written
- o_exec_cycles  out  32  cycles from o_start to i_complete

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters 0. Reset asserted in any state aborts immediately. No further RAM writes occur after the reset edge.
- States: IDLE -> LOAD_CTX -> INIT_STATE -> START -> WAIT_CPL -> DONE -> IDLE; ERR -> IDLE.
- IDLE:
  - On i_run: latch i_qbit_num, clear o_err, o_ctx_count and o_exec_cycles.
  - If qbit_num < PE_NUM_WIDTH+1 or qbit_num > STATE_ADDR_WIDTH+PE_NUM_WIDTH, go to ERR. Otherwise go to LOAD_CTX.
- LOAD_CTX:
  - s_ctx_ready=1.
  - Each handshake (valid&&ready) produces, on the next cycle, o_ctx_en=o_ctx_wea=1, o_ctx_addr=count, o_ctx_data=beat, and increments count. Write latency is 1 cycle; each write strobe lasts 1 cycle; back-to-back beats give back-to-back writes.
  - Handshake with s_ctx_last: ready drops the next cycle and the FSM goes to INIT_STATE after the final write issues.
  - Handshake when count = 2**GATE_CONTEXT_ADDR_WIDTH without last: the beat is not written and the FSM goes to ERR.
  - Valid low stalls indefinitely.
- INIT_STATE:
  - Writes N = 2**(qbit_num-PE_NUM_WIDTH) words at addresses 0..N-1, one per cycle, with o_state_ena=o_state_wea=1.
  - Address 0 data: top lane (bits [PE_NUM*64-1 -: 64]) = {1<<NUM_FRAC_BIT as DATA_WIDTH real, 0 imag}. For defaults this is 256'h40000000_00000000 followed by 192 zero bits. All other lanes and words are 0.
  - After word N-1, go to START.
- START: o_start=1 for exactly 1 cycle; the exec counter resets to 0. Go to WAIT_CPL.
- WAIT_CPL:
  - Exec counter increments every cycle and saturates at 2**32-1.
  - When i_complete=1: o_exec_cycles=counter+1, go to DONE.
  - When the counter reaches TIMEOUT_CYCLES: go to ERR.
  - i_complete outside WAIT_CPL is ignored.
- DONE: o_done=1 for 1 cycle, then IDLE.
- ERR: o_err=1 (sticky), s_ctx_ready=0, no writes, return to IDLE next cycle.
- i_run while busy is ignored.
- Simultaneous i_run and rst: rst wins.

Test Plan:
- qbit=9: 135 beats with last on beat 135, valid always high -> 135 consecutive writes at addr 0..134 with data matching; o_ctx_count=135; 128 state writes at addr 0..127; addr 0 = 256'h40000000_00000000_0…0, rest 0; single o_start pulse.
- Random valid gaps on the ctx stream -> writes only on handshakes; addresses are contiguous with no duplicates; data order preserved.
- i_complete model asserted 500 cycles after o_start -> o_exec_cycles=500, o_done pulses once, FSM back in IDLE, o_busy=0.
- i_qbit_num=2 -> ERR next cycle, o_err=1, no ctx or state writes. Then i_run with qbit=3 -> o_err clears; N=2 state words written.
- Force complete never arrives, TIMEOUT_CYCLES=100 -> o_err=1 100 cycles after o_start, no o_done.
- Assert rst mid-INIT_STATE (after 10 words) -> next cycle all outputs 0, IDLE, no further writes. A fresh i_run completes normally.

Source files
------------

// File: rtl/qea_run_sequencer.sv
// Run sequencer for the QEA core: streams gate contexts into context RAM, seeds
// the |0..0> state, launches a run and measures its execution time.
module qea_run_sequencer #(
   parameter int unsigned PE_NUM_WIDTH            = 2,
   parameter int unsigned PE_NUM                  = 4,
   parameter int unsigned DATA_WIDTH              = 32,
   parameter int unsigned STATE_DATA_WIDTH        = 64,
   parameter int unsigned STATE_ADDR_WIDTH        = 16,
   parameter int unsigned GATE_CONTEXT_DATA_WIDTH = 64,
   parameter int unsigned GATE_CONTEXT_ADDR_WIDTH = 16,
   parameter int unsigned MAX_QBIT_WIDTH          = 6,
   parameter int unsigned NUM_FRAC_BIT            = 30,
   parameter int unsigned TIMEOUT_CYCLES          = 1000000
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 i_run,
   input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
   input  logic                                 s_ctx_valid,
   output logic                                 s_ctx_ready,
   input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   s_ctx_data,
   input  logic                                 s_ctx_last,
   output logic                                 o_ctx_en,
   output logic                                 o_ctx_wea,
   output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
   output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
   output logic                                 o_state_ena,
   output logic                                 o_state_wea,
   output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
   output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
   output logic                                 o_start,
   input  logic                                 i_complete,
   output logic                                 o_busy,
   output logic                                 o_done,
   output logic                                 o_err,
   output logic [GATE_CONTEXT_ADDR_WIDTH:0]     o_ctx_count,
   output logic [31:0]                          o_exec_cycles
);

   localparam int unsigned CNT_W   = GATE_CONTEXT_ADDR_WIDTH + 1;
   localparam int unsigned LANES_W = PE_NUM * STATE_DATA_WIDTH;

   localparam logic [CNT_W-1:0]          CTX_FULL = CNT_W'(1) << GATE_CONTEXT_ADDR_WIDTH;
   localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MIN = MAX_QBIT_WIDTH'(PE_NUM_WIDTH + 1);
   localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MAX = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH);
   localparam logic [MAX_QBIT_WIDTH-1:0] PE_SHIFT = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
   localparam logic [31:0]               TIMEOUT  = 32'(TIMEOUT_CYCLES);
   localparam logic [DATA_WIDTH-1:0]     FX_ONE   = DATA_WIDTH'(1) << NUM_FRAC_BIT;
   // Amplitude 1.0+0j in the top lane of word 0; every other amplitude is zero.
   localparam logic [LANES_W-1:0]        INIT_WORD0 =
      LANES_W'({FX_ONE, DATA_WIDTH'(0)}) << (LANES_W - STATE_DATA_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_CTX,
      S_INIT_STATE,
      S_START,
      S_WAIT_CPL,
      S_DONE,
      S_ERR
   } state_t;

   state_t                               state_q, state_d;
   logic [MAX_QBIT_WIDTH-1:0]            qbit_q, qbit_d;
   logic                                 last_seen_q, last_seen_d;
   logic [CNT_W-1:0]                     ctx_count_q, ctx_count_d;
   logic                                 ctx_en_q, ctx_en_d;
   logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ctx_addr_q, ctx_addr_d;
   logic [GATE_CONTEXT_DATA_WIDTH-1:0]   ctx_data_q, ctx_data_d;
   logic [STATE_ADDR_WIDTH-1:0]          init_idx_q, init_idx_d;
   logic [31:0]                          exec_cnt_q, exec_cnt_d;
   logic [31:0]                          exec_cycles_q, exec_cycles_d;
   logic                                 err_q, err_d;

   logic [STATE_ADDR_WIDTH:0]            n_words;
   logic [STATE_ADDR_WIDTH-1:0]          init_last;
   logic [31:0]                          exec_inc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         qbit_q        <= '0;
         last_seen_q   <= 1'b0;
         ctx_count_q   <= '0;
         ctx_en_q      <= 1'b0;
         ctx_addr_q    <= '0;
         ctx_data_q    <= '0;
         init_idx_q    <= '0;
         exec_cnt_q    <= '0;
         exec_cycles_q <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         qbit_q        <= qbit_d;
         last_seen_q   <= last_seen_d;
         ctx_count_q   <= ctx_count_d;
         ctx_en_q      <= ctx_en_d;
         ctx_addr_q    <= ctx_addr_d;
         ctx_data_q    <= ctx_data_d;
         init_idx_q    <= init_idx_d;
         exec_cnt_q    <= exec_cnt_d;
         exec_cycles_q <= exec_cycles_d;
         err_q         <= err_d;
      end
   end

   always_comb begin
      n_words   = (STATE_ADDR_WIDTH+1)'(1) << (qbit_q - PE_SHIFT);
      init_last = STATE_ADDR_WIDTH'(n_words - (STATE_ADDR_WIDTH+1)'(1));
      exec_inc  = (exec_cnt_q == '1) ? exec_cnt_q : exec_cnt_q + 32'd1;
   end

   always_comb begin
      state_d       = state_q;
      qbit_d        = qbit_q;
      last_seen_d   = last_seen_q;
      ctx_count_d   = ctx_count_q;
      ctx_en_d      = 1'b0;
      ctx_addr_d    = ctx_addr_q;
      ctx_data_d    = ctx_data_q;
      init_idx_d    = init_idx_q;
      exec_cnt_d    = exec_cnt_q;
      exec_cycles_d = exec_cycles_q;
      err_d         = err_q;
      s_ctx_ready   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_run) begin
               qbit_d        = i_qbit_num;
               err_d         = 1'b0;
               ctx_count_d   = '0;
               exec_cycles_d = '0;
               last_seen_d   = 1'b0;
               init_idx_d    = '0;
               if (i_qbit_num < QBIT_MIN || i_qbit_num > QBIT_MAX) begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_LOAD_CTX;
               end
            end
         end

         S_LOAD_CTX: begin
            // One extra cycle after the last beat lets its write issue before
            // state initialisation begins.
            if (last_seen_q) begin
               state_d     = S_INIT_STATE;
               last_seen_d = 1'b0;
            end else begin
               s_ctx_ready = 1'b1;
               if (s_ctx_valid) begin
                  // A full context RAM cannot take another beat, last or not.
                  if (ctx_count_q == CTX_FULL) begin
                     state_d = S_ERR;
                     err_d   = 1'b1;
                  end else begin
                     ctx_en_d    = 1'b1;
                     ctx_addr_d  = ctx_count_q[GATE_CONTEXT_ADDR_WIDTH-1:0];
                     ctx_data_d  = s_ctx_data;
                     ctx_count_d = ctx_count_q + CNT_W'(1);
                     last_seen_d = s_ctx_last;
                  end
               end
            end
         end

         S_INIT_STATE: begin
            if (init_idx_q == init_last) begin
               state_d = S_START;
            end else begin
               init_idx_d = init_idx_q + STATE_ADDR_WIDTH'(1);
            end
         end

         S_START: begin
            exec_cnt_d = '0;
            state_d    = S_WAIT_CPL;
         end

         S_WAIT_CPL: begin
            if (i_complete) begin
               exec_cycles_d = exec_inc;
               state_d       = S_DONE;
            end else begin
               exec_cnt_d = exec_inc;
               if (exec_inc == TIMEOUT) begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end
            end
         end

         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      o_ctx_en      = ctx_en_q;
      o_ctx_wea     = ctx_en_q;
      o_ctx_addr    = ctx_addr_q;
      o_ctx_data    = ctx_data_q;
      o_state_ena   = (state_q == S_INIT_STATE);
      o_state_wea   = (state_q == S_INIT_STATE);
      o_state_addra = (state_q == S_INIT_STATE) ? init_idx_q : '0;
      o_state_dina  = (state_q == S_INIT_STATE && init_idx_q == '0) ? INIT_WORD0 : '0;
      o_start       = (state_q == S_START);
      o_busy        = (state_q != S_IDLE);
      o_done        = (state_q == S_DONE);
      o_err         = err_q;
      o_ctx_count   = ctx_count_q;
      o_exec_cycles = exec_cycles_q;
   end

endmodule

// File: tb/tb_qea_run_sequencer.sv
// Directed bench for qea_run_sequencer: table of run vectors plus hand-written
// sequences for completion latency, timeout and mid-initialisation reset.
module tb_qea_run_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, i_run, s_ctx_valid, s_ctx_last, i_complete, to_complete;
   logic [5:0]    i_qbit_num;
   logic [63:0]   s_ctx_data;

   logic          s_ctx_ready, o_ctx_en, o_ctx_wea, o_state_ena, o_state_wea;
   logic [15:0]   o_ctx_addr, o_state_addra;
   logic [63:0]   o_ctx_data;
   logic [255:0]  o_state_dina;
   logic          o_start, o_busy, o_done, o_err;
   logic [16:0]   o_ctx_count;
   logic [31:0]   o_exec_cycles;

   logic          to_ready, to_ctx_en, to_ctx_wea, to_state_ena, to_state_wea;
   logic [15:0]   to_ctx_addr, to_state_addra;
   logic [63:0]   to_ctx_data;
   logic [255:0]  to_state_dina;
   logic          to_start, to_busy, to_done, to_err;
   logic [16:0]   to_ctx_count;
   logic [31:0]   to_exec_cycles;

   qea_run_sequencer dut (
      .clk(clk), .rst(rst), .i_run(i_run), .i_qbit_num(i_qbit_num),
      .s_ctx_valid(s_ctx_valid), .s_ctx_ready(s_ctx_ready), .s_ctx_data(s_ctx_data),
      .s_ctx_last(s_ctx_last), .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea),
      .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data), .o_state_ena(o_state_ena),
      .o_state_wea(o_state_wea), .o_state_addra(o_state_addra), .o_state_dina(o_state_dina),
      .o_start(o_start), .i_complete(i_complete), .o_busy(o_busy), .o_done(o_done),
      .o_err(o_err), .o_ctx_count(o_ctx_count), .o_exec_cycles(o_exec_cycles)
   );

   // Second instance with a short timeout; its completion never arrives.
   qea_run_sequencer #(.TIMEOUT_CYCLES(100)) dut_to (
      .clk(clk), .rst(rst), .i_run(i_run), .i_qbit_num(i_qbit_num),
      .s_ctx_valid(s_ctx_valid), .s_ctx_ready(to_ready), .s_ctx_data(s_ctx_data),
      .s_ctx_last(s_ctx_last), .o_ctx_en(to_ctx_en), .o_ctx_wea(to_ctx_wea),
      .o_ctx_addr(to_ctx_addr), .o_ctx_data(to_ctx_data), .o_state_ena(to_state_ena),
      .o_state_wea(to_state_wea), .o_state_addra(to_state_addra), .o_state_dina(to_state_dina),
      .o_start(to_start), .i_complete(to_complete), .o_busy(to_busy), .o_done(to_done),
      .o_err(to_err), .o_ctx_count(to_ctx_count), .o_exec_cycles(to_exec_cycles)
   );

   typedef struct {
      int unsigned qbit;
      int unsigned nbeats;
      bit          gaps;
      int unsigned cpl;
      bit          exp_err;
      int unsigned exp_words;
   } vec_t;

   localparam logic [255:0] W0 = {64'h40000000_00000000, 192'h0};

   int unsigned errors = 0;
   int unsigned checks = 0;

   logic [15:0]  ca[$];
   logic [63:0]  cd[$];
   logic [15:0]  sa[$];
   logic [255:0] sd[$];
   int unsigned  start_cnt, done_cnt, cyc;
   int unsigned  to_start_cyc, to_err_cyc, to_done_cnt;
   logic         to_err_prev;

   always @(negedge clk) begin
      cyc++;
      if (o_ctx_en && o_ctx_wea) begin
         ca.push_back(o_ctx_addr);
         cd.push_back(o_ctx_data);
      end
      if (o_state_ena && o_state_wea) begin
         sa.push_back(o_state_addra);
         sd.push_back(o_state_dina);
      end
      if (o_start) start_cnt++;
      if (o_done) done_cnt++;
      if (to_start) to_start_cyc = cyc;
      if (to_err && !to_err_prev) to_err_cyc = cyc;
      to_err_prev = to_err;
      if (to_done) to_done_cnt++;
   end

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] beat_word(input int unsigned tag, input int unsigned i);
      return {16'hC7C7, 16'(tag), 32'(i) * 32'h9E3779B9};
   endfunction

   task automatic clear_mon();
      ca.delete(); cd.delete(); sa.delete(); sd.delete();
      start_cnt = 0; done_cnt = 0;
   endtask

   task automatic send_beats(input int unsigned n, input bit gaps, input int unsigned tag,
                             output bit ok);
      bit got;
      ok = 1'b1;
      for (int unsigned i = 0; i < n && ok; i++) begin
         if (gaps) begin
            s_ctx_valid = 1'b0;
            repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
         end
         s_ctx_valid = 1'b1;
         s_ctx_data  = beat_word(tag, i);
         s_ctx_last  = (i == n - 1);
         got = 1'b0;
         for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            got = s_ctx_ready;
            @(posedge clk); #1;
         end
         i_complete = 1'b0;
         if (!got) ok = 1'b0;
      end
      s_ctx_valid = 1'b0;
      s_ctx_last  = 1'b0;
   endtask

   task automatic run(input vec_t v, input int unsigned tag);
      bit ok;
      int unsigned mism, budget;
      clear_mon();
      i_qbit_num = 6'(v.qbit);
      i_run = 1'b1;
      @(posedge clk); #1;
      i_run = 1'b0;
      @(negedge clk);
      if (v.exp_err) begin
         check("err_flag", o_err, 1);
         check("err_busy", o_busy, 1);
         check("err_ready", s_ctx_ready, 0);
         @(posedge clk); #1;
         @(negedge clk);
         check("err_idle", o_busy, 0);
         check("err_sticky", o_err, 1);
         repeat (3) @(negedge clk);
         check("err_no_writes", ca.size() + sa.size() + start_cnt, 0);
         return;
      end
      check("err_clear", o_err, 0);
      check("ctx_count_clear", o_ctx_count, 0);
      @(posedge clk); #1;
      i_complete = 1'b1;  // must be ignored outside WAIT_CPL
      send_beats(v.nbeats, v.gaps, tag, ok);
      check("ctx_handshake", ok, 1);
      ok = 1'b0;
      budget = 0;
      while (!ok && budget < 70000) begin
         @(negedge clk);
         ok = o_start;
         budget++;
      end
      check("start_seen", ok, 1);
      for (int unsigned k = 1; k <= v.cpl; k++) begin
         @(posedge clk); #1;
         i_run      = (k == 5 && v.cpl >= 10);  // busy request must be ignored
         i_complete = (k == v.cpl);
      end
      @(posedge clk); #1;
      i_run = 1'b0;
      i_complete = 1'b0;
      @(negedge clk);
      check("done_pulse", o_done, 1);
      check("exec_cycles", o_exec_cycles, v.cpl);
      check("ctx_count", o_ctx_count, v.nbeats);
      check("no_err", o_err, 0);
      @(negedge clk);
      check("idle_after_done", {o_busy, o_done}, 0);
      mism = 0;
      for (int unsigned i = 0; i < ca.size(); i++)
         if (ca[i] !== 16'(i) || cd[i] !== beat_word(tag, i)) mism++;
      check("ctx_wr_count", ca.size(), v.nbeats);
      check("ctx_wr_content", mism, 0);
      mism = 0;
      for (int unsigned i = 0; i < sa.size(); i++)
         if (sa[i] !== 16'(i) || sd[i] !== ((i == 0) ? W0 : 256'h0)) mism++;
      check("state_wr_count", sa.size(), v.exp_words);
      check("state_wr_content", mism, 0);
      check("start_once", start_cnt, 1);
      check("done_once", done_cnt, 1);
   endtask

   vec_t tbl [9];

   initial begin
      bit ok;
      int delay;
      tbl = '{
         '{4,  6, 1, 3,  0, 4},
         '{2,  0, 0, 0,  1, 0},
         '{3,  5, 1, 1,  0, 2},
         '{19, 0, 0, 0,  1, 0},
         '{5,  1, 0, 12, 0, 8},
         '{0,  0, 0, 0,  1, 0},
         '{6,  3, 0, 2,  0, 16},
         '{18, 1, 0, 4,  0, 65536},
         '{20, 0, 0, 0,  1, 0}
      };
      rst = 1'b1; i_run = 1'b0; i_qbit_num = '0; s_ctx_valid = 1'b0; s_ctx_last = 1'b0;
      s_ctx_data = '0; i_complete = 1'b0; to_complete = 1'b0;
      to_err_prev = 1'b0; to_start_cyc = 0; to_err_cyc = 0; to_done_cnt = 0; cyc = 0;
      repeat (3) @(posedge clk);
      #1;
      i_run = 1'b1;  // reset wins over a simultaneous request
      i_qbit_num = 6'd4;
      @(negedge clk);
      check("rst_busy", o_busy, 0);
      check("rst_ready", s_ctx_ready, 0);
      check("rst_strobes", {o_ctx_en, o_ctx_wea, o_state_ena, o_state_wea, o_start, o_done, o_err}, 0);
      check("rst_counts", {o_ctx_count, o_exec_cycles}, 0);
      check("rst_addr_data", {o_state_addra, o_state_dina, o_ctx_addr, o_ctx_data}, 0);
      @(posedge clk); #1;
      i_run = 1'b0;
      rst = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      // 500-cycle completion on the main instance; the short-timeout instance
      // runs in lockstep and must time out instead.
      run('{3, 4, 0, 500, 0, 2}, 1);
      delay = int'(to_err_cyc) - int'(to_start_cyc);
      check("to_err", to_err, 1);
      check("to_delay", (delay == 100 || delay == 101), 1);
      check("to_no_done", to_done_cnt, 0);
      check("to_idle", to_busy, 0);

      run('{9, 135, 0, 7, 0, 128}, 2);

      // Reset during state initialisation after ten words.
      clear_mon();
      i_qbit_num = 6'd9;
      i_run = 1'b1;
      @(posedge clk); #1;
      i_run = 1'b0;
      send_beats(2, 0, 3, ok);
      check("rst_mid_beats", ok, 1);
      ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         ok = o_state_ena && (o_state_addra == 16'd9);
      end
      check("rst_mid_reached", ok, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_busy", o_busy, 0);
      check("rst_mid_strobes", {o_ctx_en, o_state_ena, o_state_wea, o_start, o_done, o_err}, 0);
      check("rst_mid_outs", {o_state_addra, o_state_dina, o_ctx_count, o_exec_cycles}, 0);
      repeat (20) @(negedge clk);
      check("rst_mid_state_writes", sa.size(), 10);
      check("rst_mid_ctx_writes", ca.size(), 2);
      @(posedge clk); #1;

      for (int t = 0; t < $size(tbl); t++) run(tbl[t], 32'(t) + 10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule
